// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared types for the configuration-chain loader: FSM state encoding and
// the sizing helper for the chain bit counter.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_FETCH,
        S_LD_SHIFT,
        S_RB_SHIFT,
        S_RB_PUSH,
        S_DONE
    } ccff_ld_state_e;

    // The counter must be able to hold CHAIN_LENGTH itself, not just CHAIN_LENGTH-1.
    function automatic int bit_cnt_width(input int chain_length);
        return (chain_length < 1) ? 1 : $clog2(chain_length + 1);
    endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Host-side bus of the loader: commands, load-word and readback-word
// handshakes, and status.
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 8
) ();
    logic              cmd_load;
    logic              cmd_readback;
    logic [WORD_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              busy;
    logic              done;

    modport master (
        output cmd_load, cmd_readback, wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid, busy, done
    );

    modport slave (
        input  cmd_load, cmd_readback, wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid, busy, done
    );
endinterface

// File: rtl/ccff_bitstream_loader_serdes.sv
// Word serializer/deserializer: tx shift register (MSB first), rx shift
// register (tail bits enter at LSB) and the bit index within the current word.
module ccff_word_serdes #(
    parameter int WORD_W = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              tx_load_i,
    input  logic [WORD_W-1:0] tx_word_i,
    input  logic              tx_shift_i,
    input  logic              rx_shift_i,
    input  logic              rx_bit_i,
    input  logic              idx_clr_i,
    output logic              tx_msb_o,
    output logic [WORD_W-1:0] rx_word_o,
    output logic              last_bit_o
);
    localparam int IDX_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] tx_q, tx_d;
    logic [WORD_W-1:0] rx_q, rx_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  shamt;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        tx_d  = tx_q;
        rx_d  = rx_q;
        idx_d = idx_q;
        if (tx_load_i) begin
            tx_d = tx_word_i;
        end else if (tx_shift_i) begin
            tx_d = {tx_q[WORD_W-2:0], 1'b0};
        end
        if (rx_shift_i) begin
            rx_d = {rx_q[WORD_W-2:0], rx_bit_i};
        end
        if (idx_clr_i || tx_load_i) begin
            idx_d = '0;
        end else if (tx_shift_i || rx_shift_i) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values;
    // the reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            tx_q  <= '0;
            rx_q  <= '0;
            idx_q <= '0;
        end else begin
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            idx_q <= idx_d;
        end
    end

    // Shifting by the unfilled count left-aligns a partial word and zero-fills its low bits.
    assign shamt      = IDX_W'(WORD_W) - idx_q;
    assign rx_word_o  = rx_q << shamt;
    assign tx_msb_o   = tx_q[WORD_W-1];
    assign last_bit_o = (idx_q == IDX_W'(WORD_W - 1));
endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain controller: serializes host words into the chain
// (load) or circulates the chain while packing tail bits into words (readback).
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LENGTH = 2048,
    parameter int WORD_W       = 8
) (
    input  logic                    prog_clk,
    input  logic                    pReset,
    ccff_bitstream_loader_if.slave  bus,
    output logic                    ccff_head,
    input  logic                    ccff_tail,
    output logic                    shift_en
);
    localparam int               CNT_W    = bit_cnt_width(CHAIN_LENGTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LENGTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LENGTH);

    ccff_ld_state_e   state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic tx_load, tx_shift, rx_shift, idx_clr;
    logic tx_msb, word_last;
    logic [WORD_W-1:0] rx_word;

    ccff_word_serdes #(.WORD_W(WORD_W)) u_serdes (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .tx_load_i  (tx_load),
        .tx_word_i  (bus.wr_data),
        .tx_shift_i (tx_shift),
        .rx_shift_i (rx_shift),
        .rx_bit_i   (ccff_tail),
        .idx_clr_i  (idx_clr),
        .tx_msb_o   (tx_msb),
        .rx_word_o  (rx_word),
        .last_bit_o (word_last)
    );

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_load) begin
                    state_d   = S_LD_FETCH;
                    bit_cnt_d = '0;
                end else if (bus.cmd_readback) begin
                    state_d   = S_RB_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            S_LD_FETCH: begin
                if (bus.wr_valid) state_d = S_LD_SHIFT;
            end
            S_LD_SHIFT: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_CNT) state_d = S_DONE;
                else if (word_last)        state_d = S_LD_FETCH;
            end
            S_RB_SHIFT: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (word_last || bit_cnt_q == LAST_CNT) state_d = S_RB_PUSH;
            end
            S_RB_PUSH: begin
                if (bus.rd_ready) state_d = (bit_cnt_q == FULL_CNT) ? S_DONE : S_RB_SHIFT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.wr_ready = 1'b0;
        bus.rd_valid = 1'b0;
        bus.done     = 1'b0;
        bus.busy     = (state_q != S_IDLE);
        bus.rd_data  = rx_word;
        shift_en     = 1'b0;
        ccff_head    = 1'b0;
        tx_load      = 1'b0;
        tx_shift     = 1'b0;
        rx_shift     = 1'b0;
        idx_clr      = 1'b0;
        unique case (state_q)
            S_IDLE: idx_clr = bus.cmd_readback && !bus.cmd_load;
            S_LD_FETCH: begin
                bus.wr_ready = 1'b1;
                tx_load      = bus.wr_valid;
            end
            S_LD_SHIFT: begin
                shift_en  = 1'b1;
                ccff_head = tx_msb;
                tx_shift  = 1'b1;
            end
            // Tail loops straight back to head so readback leaves the chain intact.
            S_RB_SHIFT: begin
                shift_en  = 1'b1;
                ccff_head = ccff_tail;
                rx_shift  = 1'b1;
            end
            S_RB_PUSH: begin
                bus.rd_valid = 1'b1;
                idx_clr      = bus.rd_ready;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Configuration-chain host-side controller. It sits between a word-oriented bitstream source and the fabric's configuration flip-flop chain. In load mode it serializes incoming words onto `ccff_head` and asserts a shift-enable for exactly `CHAIN_LENGTH` bits. In readback mode it circulates the chain tail back into the head, so configuration is preserved, and packs the tail bits into words for the host.

## Interface
- `CHAIN_LENGTH`, default 2048: total configuration bits in the chain (≥1).
- `WORD_W`, default 8: host word width (≥2).
- `prog_clk`  in  1  single clock; all logic on the rising edge.
- `pReset`  in  1  synchronous, active-high reset.
- `cmd_load`  in  1  one-cycle request; accepted only in IDLE.
- `cmd_readback`  in  1  one-cycle request; accepted only in IDLE. If asserted with `cmd_load` in the same cycle, `cmd_load` wins.
- `wr_data`  in  WORD_W  bitstream word, MSB shifted first.
- `wr_valid` / `wr_ready`  in / out  1  load-word handshake.
- `rd_data`  out  WORD_W  readback word, MSB = earliest tail bit.
- `rd_valid` / `rd_ready`  out / in  1  readback-word handshake.
- `ccff_head`  out  1  serial data into the chain.
- `ccff_tail`  in  1  serial data out of the chain.
- `shift_en`  out  1  chain advances on the edge ending the cycle in which `shift_en` = 1 (gates the fabric `prog_clk`).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on operation completion.

## Operation
- States: IDLE, LD_FETCH, LD_SHIFT, RB_SHIFT, RB_PUSH, DONE.
- IDLE:
  - `cmd_load` → LD_FETCH.
  - `cmd_readback` → RB_SHIFT.
  - Bit counter `bit_cnt` (width `$clog2(CHAIN_LENGTH+1)`) is cleared to 0 on entry to either mode.
- LD_FETCH:
  - `wr_ready` = 1.
  - On `wr_valid & wr_ready`, latch the word into the tx shift register, clear the word bit index, and go to LD_SHIFT.
  - `shift_en` = 0 while waiting, so the chain holds.
- LD_SHIFT:
  - Each cycle: `shift_en` = 1, `ccff_head` = tx MSB, tx shifts left, `bit_cnt`++.
  - When `bit_cnt` reaches `CHAIN_LENGTH`, go to DONE. Unused low bits of the final word are discarded.
  - Otherwise, after `WORD_W` bits, return to LD_FETCH.
- RB_SHIFT:
  - `ccff_head` = `ccff_tail` (combinational mux) and `shift_en` = 1.
  - The `ccff_tail` value is shifted into the rx register LSB, and `bit_cnt`++.
  - After `WORD_W` bits, or when `bit_cnt` reaches `CHAIN_LENGTH`, go to RB_PUSH.
- RB_PUSH:
  - `rd_valid` = 1 and `shift_en` = 0.
  - A partial final word is left-aligned with zero fill in the low bits.
  - On `rd_ready`, go to RB_SHIFT, or to DONE if `bit_cnt` = `CHAIN_LENGTH`.
  - `rd_data` is stable while `rd_valid` is high.
- DONE: `done` = 1 for one cycle, then IDLE.
- Commands arriving while `busy` = 1 are ignored; no queuing.
- After a readback, the chain contents equal their pre-readback contents.

## Timing
- Reset values:
  - `wr_ready`, `rd_valid`, `shift_en`, `busy`, `done`, `ccff_head` = 0.
  - `rd_data` = 0.
  - State = IDLE, counters = 0.
- `pReset` mid-operation aborts immediately. The next cycle is IDLE with all outputs at reset values. Chain contents are undefined.
- Load:
  - First `shift_en` is 1 cycle after the word handshake.
  - One bit per cycle with no bubbles within a word.
  - There is a minimum 1-cycle bubble (LD_FETCH) between words.
- Readback:
  - First `shift_en` is 1 cycle after the command.
  - `rd_valid` rises the cycle after the last bit of a word is sampled.
- `done` is asserted exactly one cycle after the final shift (load) or final accepted `rd_data` (readback).
- Total `shift_en`-high cycles per operation = `CHAIN_LENGTH`, exactly.

## Structure
- Shared package `ccff_loader_pkg`:
  - state enum `ccff_ld_state_e`;
  - a helper function for the `bit_cnt` width.
- The optional sub-module `ccff_word_serdes` holds the tx/rx shift registers and the word bit index. The FSM and `bit_cnt` stay in the top module.

## Test plan
- Load, `CHAIN_LENGTH`=16, `WORD_W`=8, words 0xA5 then 0x3C, chain model of 16 flops → `ccff_head` sequence 1010_0101_0011_1100, 16 `shift_en` cycles, one `done` pulse, model holds the pattern.
- `wr_valid` withheld 5 cycles between words → `shift_en` = 0 for those cycles; final chain contents unchanged from the unstalled run.
- `CHAIN_LENGTH`=12, words 0xFF, 0x9X → exactly 12 shifts; bits 1,0,0,1 from the second word are used and its low nibble is discarded; `done` asserted.
- Readback after the 0xA5/0x3C load with `rd_ready` toggling → `rd_data` = 0xA5 then 0x3C, 16 shifts, chain still 0xA53C. With `CHAIN_LENGTH`=12 the final word is left-aligned and zero-filled.
- `cmd_readback` during a load, and simultaneous `cmd_load` + `cmd_readback` in IDLE → the first is ignored; the second starts a load.
- `pReset` asserted mid-LD_SHIFT → next cycle `busy`, `shift_en`, `wr_ready` = 0 and state = IDLE; a following load completes normally.
